piho_core: RTL and testbench
============================

// Module: piho_core
// PURPOSE
//  Hit-or-miss Monte-Carlo pi estimator (PIHO) driving one port of a 64-bit block RAM.
//  After reset it streams N_SAMPLES pre-loaded random words out of the BRAM.
//  It counts the points that fall inside the unit quarter-circle and writes the totals back to the BRAM.
//  It then raises finish. Sits beside the blk_mem_gen_0 data RAM; the host preloads samples and reads results.
// PARAMETERS
//  N_SAMPLES    1024        number of 64-bit sample words to consume (>=1)
//  BASE_ADDR    32'h0000    byte address of first sample word
//  RESULT_ADDR  32'h8000    byte address of result word; must lie outside the sample region
//  RD_LAT       1           BRAM read latency in cycles (1 or 2)
// PORTS
//  clk        in   1   single system clock; all logic on rising edge
//  rst        in   1   asynchronous, active-low reset
//  bram_dout  in   64  BRAM read data, valid RD_LAT cycles after an enabled read
//  data       out  32  hit count (points inside circle)
//  data1      out  32  samples processed so far
//  data2      out  32  cycle counter since reset release; freezes when finish rises
//  bram_din   out  64  BRAM write data
//  bram_addr  out  32  BRAM byte address, always 8-byte aligned
//  bram_en    out  1   BRAM enable
//  bram_rst   out  1   BRAM output-register reset; tied 0
//  bram_we    out  8   BRAM byte write enables (8'hFF or 0)
//  finish     out  1   run complete; level, held until reset
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all outputs 0; FSM to IDLE; counters and pipeline valids cleared.
//   - Reset mid-run aborts the run with no result write; the next release starts a fresh run.
//  FSM states:
//   - IDLE: first clock after rst=1, go to RUN; data2 starts counting.
//   - RUN: read one sample per cycle.
//     - Drive bram_en=1, bram_we=0, bram_addr=BASE_ADDR+8*i for i=0..N_SAMPLES-1.
//     - After issuing i=N_SAMPLES-1, go to DRAIN.
//   - DRAIN: bram_en=0; wait until every in-flight sample is accumulated (RD_LAT+2 cycles), then go to WRITE.
//   - WRITE: one cycle only.
//     - bram_en=1, bram_we=8'hFF, bram_addr=RESULT_ADDR.
//     - bram_din={data1,data}, i.e. [63:32]=samples, [31:0]=hits.
//   - DONE: bram_en=0, bram_we=0, finish=1; data/data1/data2 frozen. Leave only by reset.
//  Datapath:
//   - Read-valid shift register of depth RD_LAT tags returning words.
//   - Sample word: x=bram_dout[15:0], y=bram_dout[47:32], unsigned Q0.16; other bits ignored.
//   - Stage 1 (registered): sq = x*x + y*y, 33-bit unsigned, no truncation.
//   - Stage 2: hit = (sq[32]==0), i.e. sq < 2^32.
//     - data1 += 1 per valid sample; data += hit.
//   - Counters are 32-bit and wrap; N_SAMPLES < 2^32 guarantees no wrap.
//  Timing and bounds:
//   - finish rises exactly N_SAMPLES+RD_LAT+5 cycles after the first clock with rst=1.
//   - data2 stops counting on the cycle finish rises and holds that value.
//   - Boundary: sq == 2^32 exactly is impossible for 16-bit inputs.
//   - sq max = 2*65535^2 (33 bits); bit 32 alone decides hit/miss.
// TESTING
//  Run every case with N_SAMPLES=16, RD_LAT=1, BRAM preloaded before reset release.
//  - All-zero samples -> data=16, data1=16, result word 64'h00000010_00000010, finish=1.
//  - All x=y=16'hFFFF -> data=0, data1=16, result word 64'h00000010_00000000.
//  - Boundary pair: word0 x=y=16'hB504 (sq=4294791200 -> hit); word1 x=y=16'hB505 (sq=4294976562 -> miss).
//    Remaining 14 words x=y=16'h8000 (sq=2^31 -> hit). Expect data=15.
//  - Upper-bits ignored: words 64'hFFFF0000_FFFF0000 -> all hits, data=16.
//  - Address/handshake check:
//    - RUN addresses 0x0,0x8,...,0x78 on consecutive cycles with we=0.
//    - Exactly one write to 0x8000 with we=8'hFF.
//    - finish and data2=22 (16+1+5) at completion.
//  - Reset asserted mid-RUN -> outputs 0 immediately, no write to RESULT_ADDR.
//    On release, the full run repeats with identical results.

Source files
------------

// File: rtl/piho_core.sv
// Hit-or-miss Monte-Carlo pi estimator: streams sample words from a BRAM port,
// counts points inside the unit quarter-circle and writes {samples, hits} back.
module piho_core #(
  parameter int unsigned N_SAMPLES   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000,
  parameter logic [31:0] RESULT_ADDR = 32'h8000,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] bram_dout,
  output logic [31:0] data,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [63:0] bram_din,
  output logic [31:0] bram_addr,
  output logic        bram_en,
  output logic        bram_rst,
  output logic [7:0]  bram_we,
  output logic        finish
);

  // state | meaning
  // IDLE  | one cycle after reset release
  // RUN   | issue one sample read per cycle
  // DRAIN | let in-flight samples reach the accumulators
  // WRITE | single-cycle result write
  // DONE  | results frozen until reset
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t            state, next_state;
  logic [31:0]       idx;
  logic [3:0]        drain_cnt;
  logic [RD_LAT-1:0] vld_sr;
  logic [32:0]       sq;
  logic              sq_vld;
  logic              issue;

  logic [15:0] x, y;
  logic [31:0] xx, yy;
  logic [32:0] sq_next;
  logic [31:0] unused_dout;

  assign x           = bram_dout[15:0];
  assign y           = bram_dout[47:32];
  assign xx          = x * x;
  assign yy          = y * y;
  assign sq_next     = {1'b0, xx} + {1'b0, yy};
  assign unused_dout = {bram_dout[63:48], bram_dout[31:16]};
  assign bram_rst    = 1'b0;

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 8'h00;
    bram_addr  = 32'h0;
    bram_din   = 64'h0;
    case (state)
      IDLE: next_state = RUN;
      RUN: begin
        issue     = 1'b1;
        bram_en   = 1'b1;
        bram_addr = BASE_ADDR + (idx << 3);
        if (idx == 32'(N_SAMPLES - 1)) next_state = DRAIN;
      end
      DRAIN: if (drain_cnt == 4'd0) next_state = WRITE;
      WRITE: begin
        bram_en    = 1'b1;
        bram_we    = 8'hFF;
        bram_addr  = RESULT_ADDR;
        bram_din   = {data1, data};
        next_state = DONE;
      end
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 32'h0;
      drain_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (issue) idx <= idx + 32'd1;
      // down-counter covering RD_LAT+2 drain cycles
      if (state == RUN) drain_cnt <= 4'(RD_LAT + 1);
      else if (state == DRAIN && drain_cnt != 4'd0) drain_cnt <= drain_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      sq     <= 33'h0;
      sq_vld <= 1'b0;
      data   <= 32'h0;
      data1  <= 32'h0;
    end else begin
      vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
      sq_vld <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) sq <= sq_next;
      if (sq_vld) begin
        data1 <= data1 + 32'd1;
        data  <= data + {31'h0, ~sq[32]};
      end
    end
  end

  // finish is registered off DONE so data2 stops on the edge finish rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data2  <= 32'h0;
      finish <= 1'b0;
    end else begin
      if (!finish) data2 <= data2 + 32'd1;
      if (state == DONE) finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_piho_core.sv
// Directed bench for piho_core (N_SAMPLES=16, RD_LAT=1) with a behavioural BRAM
// that records every read and write the core issues.
module tb_piho_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] bram_dout = 64'h0;
  logic [31:0] data, data1, data2, bram_addr;
  logic [63:0] bram_din;
  logic        bram_en, bram_rst, finish;
  logic [7:0]  bram_we;

  piho_core #(.N_SAMPLES(16), .BASE_ADDR(32'h0), .RESULT_ADDR(32'h8000), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .bram_dout(bram_dout), .data(data), .data1(data1),
    .data2(data2), .bram_din(bram_din), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_rst(bram_rst), .bram_we(bram_we), .finish(finish)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:15];
  int          cyc = 0;
  int          rd_cnt, rd_bad, wr_cnt, last_cyc;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_we;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_en && bram_we == 8'h00) bram_dout <= mem[bram_addr[6:3]];
  end

  always @(negedge clk) begin
    if (bram_en && bram_we == 8'h00) begin
      if (bram_addr != 32'(rd_cnt * 8)) rd_bad = rd_bad + 1;
      if (rd_cnt > 0 && cyc != last_cyc + 1) rd_bad = rd_bad + 1;
      last_cyc = cyc;
      rd_cnt   = rd_cnt + 1;
    end else if (bram_en) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = bram_addr;
      wr_data = bram_din;
      wr_we   = bram_we;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_cnt = 0; rd_bad = 0; wr_cnt = 0; last_cyc = 0;
    wr_addr = 32'h0; wr_data = 64'h0; wr_we = 8'h00;
  endtask

  task automatic run_case(input string name, input logic [31:0] exp_hits);
    int n;
    rst = 1'b0;
    clear_log();
    repeat (2) @(negedge clk);
    chk({name, ".rst_out"}, {data, data1, data2, finish, bram_en, bram_we}, 0);
    rst = 1'b1;
    n = 0;
    while (!finish && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk({name, ".finish"}, finish, 1);
    chk({name, ".cycles"}, n, 22);
    chk({name, ".hits"}, data, exp_hits);
    chk({name, ".samples"}, data1, 16);
    chk({name, ".data2"}, data2, 22);
    chk({name, ".wr_cnt"}, wr_cnt, 1);
    chk({name, ".wr_addr"}, wr_addr, 32'h8000);
    chk({name, ".wr_we"}, wr_we, 8'hFF);
    chk({name, ".wr_data"}, wr_data, {32'd16, exp_hits});
    chk({name, ".rd_cnt"}, rd_cnt, 16);
    chk({name, ".rd_seq"}, rd_bad, 0);
    repeat (5) @(negedge clk);
    chk({name, ".hold"}, {finish, data2, data, bram_en}, {1'b1, 32'd22, exp_hits, 1'b0});
    chk({name, ".one_wr"}, wr_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    run_case("zeros", 32'd16);

    for (int i = 0; i < 16; i++) mem[i] = 64'h0000FFFF_0000FFFF;
    run_case("maxed", 32'd0);

    mem[0] = 64'h0000B504_0000B504;
    mem[1] = 64'h0000B505_0000B505;
    for (int i = 2; i < 16; i++) mem[i] = 64'h00008000_00008000;
    run_case("boundary", 32'd15);

    for (int i = 0; i < 16; i++) mem[i] = 64'hFFFF0000_FFFF0000;
    run_case("upper", 32'd16);

    // abort part-way through RUN, then repeat the boundary pattern
    mem[0] = 64'h0000B504_0000B504;
    mem[1] = 64'h0000B505_0000B505;
    for (int i = 2; i < 16; i++) mem[i] = 64'h00008000_00008000;
    rst = 1'b0;
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort.out", {data, data1, data2, finish, bram_en, bram_we}, 0);
    repeat (30) @(negedge clk);
    chk("abort.no_wr", wr_cnt, 0);
    chk("abort.idle", {finish, bram_en, data2}, 0);
    run_case("rerun", 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
